// File: rtl/nfca_pkg.sv
// rtl/nfca_pkg.sv - shared types and constants for the NFC-A PICC->PCD Manchester decoder
//
// Purpose : half-bit classes, decoder FSM states and the SOF slice pattern.
// Ports   : none (package).
package nfca_pkg;

    typedef enum logic [1:0] {
        HB_ZERO = 2'd0,
        HB_ONE  = 2'd1,
        HB_UNK  = 2'd2
    } hb_class_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PARSE = 2'd1,
        ST_STOP  = 2'd2
    } dec_state_e;

    // Classes of {h3,h2,h1,h0} when the window holds the start bit: two quiet
    // slices followed by a '1' bit (subcarrier, then no subcarrier).
    localparam logic [7:0] SOF_PATTERN = {HB_ZERO, HB_ZERO, HB_ONE, HB_ZERO};

    function automatic logic [7:0] pack_classes(input hb_class_e h3, input hb_class_e h2,
                                                input hb_class_e h1, input hb_class_e h0);
        return {h3, h2, h1, h0};
    endfunction

endpackage

// File: rtl/nfca_rx_halfbit_cls.sv
// rtl/nfca_rx_halfbit_cls.sv - popcount classifier for one half-bit slice
//
// Purpose : counts the subcarrier samples in one half-bit slice and maps the
//           count to ONE (>= ONE_TH), ZERO (<= ZERO_TH) or UNK (in between).
// Ports   : slice_i  HALF_SAMPLES samples of one half-bit
//           cls_o    class of that slice (combinational)
module nfca_rx_halfbit_cls
    import nfca_pkg::*;
#(
    parameter int HALF_SAMPLES = 12,
    parameter int ONE_TH       = 3,
    parameter int ZERO_TH      = 1
) (
    input  logic [HALF_SAMPLES-1:0] slice_i,
    output hb_class_e               cls_o
);

    localparam int PW = $clog2(HALF_SAMPLES + 1);

    logic [PW-1:0] ones;

    always_comb begin
        ones = '0;
        for (int i = 0; i < HALF_SAMPLES; i++) begin
            ones = ones + PW'(slice_i[i]);
        end
    end

    always_comb begin
        if (int'(ones) >= ONE_TH) begin
            cls_o = HB_ONE;
        end else if (int'(ones) <= ZERO_TH) begin
            cls_o = HB_ZERO;
        end else begin
            cls_o = HB_UNK;
        end
    end

endmodule

// File: rtl/nfca_rx_manchester_dec.sv
// rtl/nfca_rx_manchester_dec.sv - ISO14443-A PICC->PCD Manchester bit decoder
//
// Purpose : finds SOF in the subcarrier sample stream, emits data bits, and
//           ends the frame on EOF, collision (optional), noise, bit limit or
//           SOF timeout.
// Ports   : clk, rstn        clock, asynchronous active-low reset
//           rx_on_i          receive window; low clears all state
//           rx_ask_en_i      sample strobe
//           rx_ask_i         subcarrier present
//           rx_bit_en_o      one-cycle pulse, rx_bit_o/rx_bit_col_o valid
//           rx_bit_o         decoded bit (collisions reported as 1)
//           rx_bit_col_o     this bit was a collision
//           rx_end_o         one-cycle pulse, frame ended
//           rx_end_col_o     a collision occurred in the frame
//           rx_end_err_o     noise, undecodable pair or too many bits
//           rx_end_tmo_o     no SOF within SOF_TIMEOUT strobes
//           rx_bit_cnt_o     data bits emitted in the current frame
//           rx_col_pos_o     index of the first collided bit
module nfca_rx_manchester_dec
    import nfca_pkg::*;
#(
    parameter  int HALF_SAMPLES = 12,
    parameter  int ONE_TH       = 3,
    parameter  int ZERO_TH      = 1,
    parameter  int COL_CONTINUE = 1,
    parameter  int MAX_BITS     = 4096,
    parameter  int SOF_TIMEOUT  = 0,
    localparam int CW           = $clog2(MAX_BITS + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          rx_on_i,
    input  logic          rx_ask_en_i,
    input  logic          rx_ask_i,
    output logic          rx_bit_en_o,
    output logic          rx_bit_o,
    output logic          rx_bit_col_o,
    output logic          rx_end_o,
    output logic          rx_end_col_o,
    output logic          rx_end_err_o,
    output logic          rx_end_tmo_o,
    output logic [CW-1:0] rx_bit_cnt_o,
    output logic [CW-1:0] rx_col_pos_o
);

    localparam int WW  = 4 * HALF_SAMPLES;
    localparam int PHW = $clog2(2 * HALF_SAMPLES);
    localparam int TW  = (SOF_TIMEOUT > 0) ? $clog2(SOF_TIMEOUT + 1) : 1;

    logic [WW-1:0]  win_q, win_d;
    hb_class_e      cls_w [4];
    hb_class_e      cls_q [4];

    dec_state_e     state_q;
    logic [PHW-1:0] phase_q;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           col_flag_q;

    logic           bit_en_q, bit_q, bit_col_q;
    logic           end_q, end_col_q, end_err_q, end_tmo_q;
    logic [CW-1:0]  bit_cnt_q, col_pos_q;

    logic           sof_hit, pair_unk, pair_eof, pair_col;
    logic           at_decide, at_max, tmo_hit;

    // Newest sample enters at the LSB, so slice 0 (h0) is the most recent half-bit.
    assign win_d = {win_q[WW-2:0], rx_ask_i};

    for (genvar g = 0; g < 4; g++) begin : g_slice
        nfca_rx_halfbit_cls #(
            .HALF_SAMPLES (HALF_SAMPLES),
            .ONE_TH       (ONE_TH),
            .ZERO_TH      (ZERO_TH)
        ) u_cls (
            .slice_i (win_q[g*HALF_SAMPLES +: HALF_SAMPLES]),
            .cls_o   (cls_w[g])
        );
    end

    // Classes are taken from the pre-shift window and registered, so every
    // decision below sees the window as it was one strobe earlier.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_q <= '0;
            for (int i = 0; i < 4; i++) cls_q[i] <= HB_ZERO;
        end else if (!rx_on_i) begin
            win_q <= '0;
            for (int i = 0; i < 4; i++) cls_q[i] <= HB_ZERO;
        end else if (rx_ask_en_i) begin
            win_q <= win_d;
            for (int i = 0; i < 4; i++) cls_q[i] <= cls_w[i];
        end
    end

    assign sof_hit   = pack_classes(cls_q[3], cls_q[2], cls_q[1], cls_q[0]) == SOF_PATTERN;
    assign pair_unk  = (cls_q[1] == HB_UNK) || (cls_q[0] == HB_UNK);
    assign pair_eof  = (cls_q[1] == HB_ZERO) && (cls_q[0] == HB_ZERO);
    assign pair_col  = (cls_q[1] == HB_ONE) && (cls_q[0] == HB_ONE);
    assign at_decide = phase_q == PHW'(2 * HALF_SAMPLES - 1);
    assign at_max    = bit_cnt_q == CW'(MAX_BITS);
    assign tmo_d     = tmo_q + TW'(1);
    assign tmo_hit   = (SOF_TIMEOUT != 0) && (tmo_d == TW'(SOF_TIMEOUT));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            tmo_q      <= '0;
            col_flag_q <= 1'b0;
            bit_en_q   <= 1'b0;
            bit_q      <= 1'b0;
            bit_col_q  <= 1'b0;
            end_q      <= 1'b0;
            end_col_q  <= 1'b0;
            end_err_q  <= 1'b0;
            end_tmo_q  <= 1'b0;
            bit_cnt_q  <= '0;
            col_pos_q  <= '0;
        end else begin
            bit_en_q <= 1'b0;
            end_q    <= 1'b0;
            if (!rx_on_i) begin
                state_q    <= ST_IDLE;
                phase_q    <= '0;
                tmo_q      <= '0;
                col_flag_q <= 1'b0;
                bit_q      <= 1'b0;
                bit_col_q  <= 1'b0;
                end_col_q  <= 1'b0;
                end_err_q  <= 1'b0;
                end_tmo_q  <= 1'b0;
                bit_cnt_q  <= '0;
                col_pos_q  <= '0;
            end else if (rx_ask_en_i) begin
                case (state_q)
                    ST_IDLE: begin
                        phase_q <= '0;
                        if (sof_hit) begin
                            state_q    <= ST_PARSE;
                            bit_cnt_q  <= '0;
                            col_flag_q <= 1'b0;
                        end else if (tmo_hit) begin
                            state_q   <= ST_STOP;
                            end_q     <= 1'b1;
                            end_tmo_q <= 1'b1;
                            end_err_q <= 1'b0;
                            end_col_q <= 1'b0;
                        end else if (SOF_TIMEOUT != 0) begin
                            tmo_q <= tmo_d;
                        end
                    end
                    ST_PARSE: begin
                        if (!at_decide) begin
                            phase_q <= phase_q + PHW'(1);
                        end else begin
                            phase_q <= '0;
                            if (pair_unk) begin
                                state_q   <= ST_STOP;
                                end_q     <= 1'b1;
                                end_err_q <= 1'b1;
                                end_tmo_q <= 1'b0;
                                end_col_q <= col_flag_q;
                            end else if (pair_eof) begin
                                state_q   <= ST_STOP;
                                end_q     <= 1'b1;
                                end_err_q <= 1'b0;
                                end_tmo_q <= 1'b0;
                                end_col_q <= col_flag_q;
                            end else if (pair_col && (COL_CONTINUE == 0)) begin
                                state_q   <= ST_STOP;
                                end_q     <= 1'b1;
                                end_err_q <= 1'b0;
                                end_tmo_q <= 1'b0;
                                end_col_q <= 1'b1;
                                col_pos_q <= bit_cnt_q;
                            end else if (at_max) begin
                                state_q   <= ST_STOP;
                                end_q     <= 1'b1;
                                end_err_q <= 1'b1;
                                end_tmo_q <= 1'b0;
                                end_col_q <= col_flag_q;
                            end else begin
                                // (ONE,ZERO) is a 1, (ZERO,ONE) a 0; a collision reads as 1.
                                bit_en_q  <= 1'b1;
                                bit_q     <= (cls_q[1] == HB_ONE);
                                bit_col_q <= pair_col;
                                bit_cnt_q <= bit_cnt_q + CW'(1);
                                if (pair_col && !col_flag_q) begin
                                    col_pos_q  <= bit_cnt_q;
                                    col_flag_q <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_STOP: begin
                        // Frame is over; wait for the receive window to close.
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign rx_bit_en_o  = bit_en_q;
    assign rx_bit_o     = bit_q;
    assign rx_bit_col_o = bit_col_q;
    assign rx_end_o     = end_q;
    assign rx_end_col_o = end_col_q;
    assign rx_end_err_o = end_err_q;
    assign rx_end_tmo_o = end_tmo_q;
    assign rx_bit_cnt_o = bit_cnt_q;
    assign rx_col_pos_o = col_pos_q;

endmodule
